// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the word-to-byte memory bridge: FSM encoding,
// word geometry, default timeout and a byte-lane extract helper.
package mem_bridge_pkg;

  localparam int BYTES_PER_WORD  = 4;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_be_scan.sv
// Lowest-set-bit finder over a 4-bit byte mask.
module mem_be_scan (
  input  logic [3:0] mask,
  output logic [1:0] idx,
  output logic       any
);

  always_comb begin
    idx = 2'd0;
    any = |mask;
    if (mask[0])      idx = 2'd0;
    else if (mask[1]) idx = 2'd1;
    else if (mask[2]) idx = 2'd2;
    else if (mask[3]) idx = 2'd3;
  end

endmodule

// File: rtl/mem_word_bridge.sv
// Splits 32-bit word requests into acknowledged byte accesses on the PSRAM
// bus, assembling read bytes and aborting with an error on a missing ack.
module mem_word_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W         = 23,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-3:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] memaddr,
  output logic [7:0]        memdatao,
  output logic              memrd,
  output logic              memwr,
  input  logic              memack,
  input  logic [7:0]        memdatai
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 2);

  state_t            state_q, state_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [3:0]        mask_q, mask_d;
  logic [1:0]        k_q, k_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_ready_d, rsp_valid_d, rsp_err_d, memrd_d, memwr_d;
  logic [31:0]       rdata_d;
  logic [ADDR_W-1:0] memaddr_d;
  logic [7:0]        memdatao_d;

  logic              accept, in_idle;
  logic [3:0]        acc_mask, rem_mask, scan_in;
  logic [1:0]        scan_idx;
  logic              scan_any;
  logic [ADDR_W-3:0] src_addr;
  logic [31:0]       src_wdata;
  logic              src_write;

  // One scanner serves both the accept decision and the post-ack next byte.
  assign in_idle   = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign acc_mask  = req_write ? req_be : 4'hF;
  assign rem_mask  = mask_q & ~(4'b0001 << k_q);
  assign scan_in   = in_idle ? acc_mask : rem_mask;
  assign src_addr  = in_idle ? req_addr : addr_q;
  assign src_wdata = in_idle ? req_wdata : wdata_q;
  assign src_write = in_idle ? req_write : write_q;

  mem_be_scan u_scan (
    .mask (scan_in),
    .idx  (scan_idx),
    .any  (scan_any)
  );

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      mask_q    <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      memaddr   <= '0;
      memdatao  <= '0;
      memrd     <= 1'b0;
      memwr     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      mask_q    <= mask_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rdata_d;
      memaddr   <= memaddr_d;
      memdatao  <= memdatao_d;
      memrd     <= memrd_d;
      memwr     <= memwr_d;
    end
  end

  // An ack on the terminal-count cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && scan_any) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (memack)                 state_d = scan_any ? ST_ISSUE : ST_IDLE;
        else if (cnt_q == CNT_LAST) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    mask_d      = mask_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    rdata_d     = rsp_rdata;
    req_ready_d = req_ready;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    memaddr_d   = memaddr;
    memdatao_d  = memdatao;
    memrd_d     = 1'b0;
    memwr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          write_d   = req_write;
          mask_d    = acc_mask;
          rdata_d   = '0;
          rsp_err_d = 1'b0;
          if (!scan_any) rsp_valid_d = 1'b1;
        end
      end
      ST_ISSUE: cnt_d = '0;
      ST_WAIT: begin
        if (memack) begin
          if (!write_q) rdata_d[{k_q, 3'b000} +: 8] = memdatai;
          mask_d = rem_mask;
          if (!scan_any) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            req_ready_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          req_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
    // Strobe for the next byte, whether from accept or after an ack.
    if ((in_idle && accept && scan_any) || (state_q == ST_WAIT && memack && scan_any)) begin
      k_d         = scan_idx;
      req_ready_d = 1'b0;
      memaddr_d   = {src_addr, scan_idx};
      memdatao_d  = get_byte(src_wdata, scan_idx);
      memrd_d     = !src_write;
      memwr_d     = src_write;
    end
  end

endmodule

// File: tb/tb_mem_word_bridge.sv
// Directed bench for mem_word_bridge with a byte-memory model that acks
// only inside a 4 KiB window, with programmable ack delay.
module tb_mem_word_bridge;

  localparam int ADDR_W = 23;
  localparam int TO     = 16;

  logic              clkin = 1'b0, rstn = 1'b0;
  logic              req_valid = 1'b0, req_write = 1'b0;
  logic [ADDR_W-3:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [3:0]        req_be = '0;
  logic              req_ready, rsp_valid, rsp_err, memrd, memwr;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] memaddr;
  logic [7:0]        memdatao;
  logic              memack = 1'b0;
  logic [7:0]        memdatai = '0;

  int checks = 0, failures = 0;
  int cyc = 0;

  mem_word_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clkin(clkin), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .memaddr(memaddr), .memdatao(memdatao), .memrd(memrd), .memwr(memwr),
    .memack(memack), .memdatai(memdatai)
  );

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  typedef struct { int c; logic [ADDR_W-1:0] a; logic [7:0] d; bit wr; } ev_t;
  ev_t log_q[$];

  logic [7:0]        mem [0:4095];
  int                ack_delay = 0;
  int                dcnt = 0;
  bit                pend = 0, pwr = 0, stray = 0;
  logic [ADDR_W-1:0] paddr = '0;
  logic [7:0]        pdat = '0;

  // Memory model: sees a strobe at a negedge, acks ack_delay+1 cycles later.
  always @(negedge clkin or negedge rstn) begin
    if (!rstn) begin
      pend = 0; memack = 1'b0; memdatai = '0;
    end else begin
      memack = 1'b0; memdatai = '0;
      if (memrd || memwr) begin
        log_q.push_back('{cyc, memaddr, memdatao, memwr});
        pend = 1; dcnt = ack_delay; paddr = memaddr; pwr = memwr; pdat = memdatao;
      end else if (pend) begin
        if (dcnt == 0) begin
          pend = 0;
          if (paddr < 4096) begin
            memack = 1'b1;
            if (pwr) mem[paddr[11:0]] = pdat;
            else     memdatai = mem[paddr[11:0]];
          end
        end else dcnt--;
      end
      if (stray) begin memack = 1'b1; memdatai = 8'h5A; stray = 0; end
    end
  end

  // Entered and left at a negedge; lat is cycles from accept to rsp_valid.
  task automatic do_req(input bit wr, input logic [ADDR_W-3:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int budget,
                        output logic [31:0] rd, output bit err, output int lat);
    int t0;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL req_ready_at_issue got=%b exp=1", req_ready); end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_be = be; t0 = cyc;
    @(negedge clkin);
    req_valid = 1'b0;
    lat = -1;
    for (int n = 0; n < budget; n++) begin
      if (rsp_valid === 1'b1) begin lat = cyc - t0; break; end
      @(negedge clkin);
    end
    rd = rsp_rdata; err = rsp_err;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clkin);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, memaddr, memdatao, memrd, memwr} !== '0) begin
      failures++; $display("FAIL reset_outputs got rdy=%b vld=%b err=%b rd=%h a=%h d=%h r=%b w=%b exp=all0",
        req_ready, rsp_valid, rsp_err, rsp_rdata, memaddr, memdatao, memrd, memwr);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clkin);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", req_ready); end
  endtask

  task automatic test_full_word();
    logic [31:0] rd; bit err; int lat, base;
    logic [7:0] exp_b [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    log_q.delete();
    do_req(1'b1, 21'h10, 32'hA1B2C3D4, 4'hF, 40, rd, err, lat);
    base = cyc - lat;
    checks++; if (lat != 9) begin failures++; $display("FAIL fw_write_lat got=%0d exp=9", lat); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL fw_write_err got=%b exp=0", err); end
    checks++; if (log_q.size() != 4) begin failures++; $display("FAIL fw_write_strobes got=%0d exp=4", log_q.size()); end
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k].c - base != 1 + 2*k || log_q[k].a !== 23'(32'h40 + k) || log_q[k].d !== exp_b[k] || !log_q[k].wr) begin
        failures++; $display("FAIL fw_write_byte%0d got cyc=%0d a=%h d=%h wr=%b exp cyc=%0d a=%h d=%h wr=1",
          k, log_q[k].c - base, log_q[k].a, log_q[k].d, log_q[k].wr, 1 + 2*k, 32'h40 + k, exp_b[k]);
      end
    end
    log_q.delete();
    do_req(1'b0, 21'h10, 32'h0, 4'h0, 40, rd, err, lat);
    checks++; if (lat != 9) begin failures++; $display("FAIL fw_read_lat got=%0d exp=9", lat); end
    checks++; if (rd !== 32'hA1B2C3D4 || err !== 1'b0) begin failures++; $display("FAIL fw_read_data got=%h err=%b exp=a1b2c3d4 err=0", rd, err); end
    checks++; if (log_q.size() != 4 || log_q[0].wr) begin failures++; $display("FAIL fw_read_strobes got=%0d exp=4 reads", log_q.size()); end
  endtask

  task automatic test_sparse();
    logic [31:0] rd; bit err; int lat, base;
    @(negedge clkin);
    log_q.delete();
    do_req(1'b1, 21'h10, 32'h11223344, 4'b1010, 40, rd, err, lat);
    base = cyc - lat;
    checks++; if (lat != 5) begin failures++; $display("FAIL sparse_lat got=%0d exp=5", lat); end
    checks++;
    if (log_q.size() != 2) begin failures++; $display("FAIL sparse_count got=%0d exp=2", log_q.size()); end
    else if (log_q[0].a !== 23'h41 || log_q[0].d !== 8'h33 || log_q[0].c - base != 1 ||
             log_q[1].a !== 23'h43 || log_q[1].d !== 8'h11 || log_q[1].c - base != 3) begin
      failures++; $display("FAIL sparse_bytes got %h/%h@%0d %h/%h@%0d exp 41/33@1 43/11@3",
        log_q[0].a, log_q[0].d, log_q[0].c - base, log_q[1].a, log_q[1].d, log_q[1].c - base);
    end
    do_req(1'b0, 21'h10, 32'h0, 4'h0, 40, rd, err, lat);
    checks++; if (rd !== 32'h11B233D4) begin failures++; $display("FAIL sparse_readback got=%h exp=11b233d4", rd); end
  endtask

  task automatic test_zero_be();
    logic [31:0] rd; bit err; int lat;
    @(negedge clkin);
    log_q.delete();
    do_req(1'b1, 21'h10, 32'hFFFFFFFF, 4'h0, 10, rd, err, lat);
    checks++; if (lat != 1 || err !== 1'b0) begin failures++; $display("FAIL zero_be_lat got=%0d err=%b exp=1 err=0", lat, err); end
    repeat (3) @(negedge clkin);
    checks++; if (log_q.size() != 0) begin failures++; $display("FAIL zero_be_strobes got=%0d exp=0", log_q.size()); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; bit err; int lat;
    @(negedge clkin);
    log_q.delete();
    do_req(1'b0, 21'h2000, 32'h0, 4'h0, 60, rd, err, lat);
    checks++; if (lat != 1 + TO) begin failures++; $display("FAIL timeout_lat got=%0d exp=%0d", lat, 1 + TO); end
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL timeout_rsp got err=%b rd=%h exp err=1 rd=0", err, rd); end
    checks++;
    if (log_q.size() != 1 || log_q[0].a !== 23'h8000 || log_q[0].wr) begin
      failures++; $display("FAIL timeout_strobes got=%0d exp=1 read at 8000", log_q.size());
    end
  endtask

  task automatic test_delayed_acks();
    logic [31:0] rd; bit err; int lat, seen;
    @(negedge clkin);
    ack_delay = 3;
    do_req(1'b0, 21'h10, 32'h0, 4'h0, 60, rd, err, lat);
    checks++; if (lat != 21 || rd !== 32'h11B233D4 || err !== 1'b0) begin
      failures++; $display("FAIL delay3 got lat=%0d rd=%h err=%b exp lat=21 rd=11b233d4 err=0", lat, rd, err); end
    ack_delay = TO - 2;
    do_req(1'b0, 21'h10, 32'h0, 4'h0, 120, rd, err, lat);
    checks++; if (lat != 4*TO + 1 || rd !== 32'h11B233D4 || err !== 1'b0) begin
      failures++; $display("FAIL ack_on_terminal got lat=%0d rd=%h err=%b exp lat=%0d rd=11b233d4 err=0", lat, rd, err, 4*TO + 1); end
    ack_delay = TO - 1;
    do_req(1'b0, 21'h10, 32'h0, 4'h0, 60, rd, err, lat);
    checks++; if (lat != TO + 1 || rd !== 32'h0 || err !== 1'b1) begin
      failures++; $display("FAIL ack_after_terminal got lat=%0d rd=%h err=%b exp lat=%0d rd=0 err=1", lat, rd, err, TO + 1); end
    ack_delay = 0;
    seen = 0;
    repeat (5) @(negedge clkin) if (rsp_valid) seen++;
    stray = 1;
    repeat (5) @(negedge clkin) if (rsp_valid) seen++;
    checks++; if (seen != 0) begin failures++; $display("FAIL stray_ack_rsp got=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; bit err; int lat;
    @(negedge clkin);
    do_req(1'b1, 21'h10, 32'h0, 4'h0, 10, rd, err, lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL b2b_first_lat got=%0d exp=1", lat); end
    do_req(1'b0, 21'h10, 32'h0, 4'h0, 40, rd, err, lat);
    checks++; if (lat != 9 || rd !== 32'h11B233D4) begin failures++; $display("FAIL b2b_second got lat=%0d rd=%h exp lat=9 rd=11b233d4", lat, rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; bit err; int lat, seen;
    @(negedge clkin);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 21'h10; req_be = 4'h0;
    @(negedge clkin);
    req_valid = 1'b0;
    repeat (2) @(negedge clkin);
    checks++; if (memrd !== 1'b1 || memaddr !== 23'h41) begin failures++; $display("FAIL mid_byte1_strobe got rd=%b a=%h exp rd=1 a=41", memrd, memaddr); end
    #1 rstn = 1'b0;
    #1;
    checks++; if ({memrd, memwr, rsp_valid, req_ready, memaddr} !== '0) begin
      failures++; $display("FAIL mid_reset_async got rd=%b wr=%b vld=%b rdy=%b a=%h exp all0", memrd, memwr, rsp_valid, req_ready, memaddr); end
    seen = 0;
    repeat (3) @(negedge clkin) if (rsp_valid) seen++;
    rstn = 1'b1;
    repeat (3) @(negedge clkin) if (rsp_valid) seen++;
    checks++; if (seen != 0) begin failures++; $display("FAIL mid_reset_rsp got=%0d exp=0", seen); end
    do_req(1'b0, 21'h10, 32'h0, 4'h0, 40, rd, err, lat);
    checks++; if (lat != 9 || rd !== 32'h11B233D4 || err !== 1'b0) begin
      failures++; $display("FAIL after_reset_read got lat=%0d rd=%h err=%b exp lat=9 rd=11b233d4 err=0", lat, rd, err); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    test_reset();
    test_full_word();
    test_sparse();
    test_zero_be();
    test_timeout();
    test_delayed_acks();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_word_bridge.md
# mem_word_bridge

Word-to-byte access sequencer in front of the byte-wide PSRAM wrapper. It accepts 32-bit word read/write requests from an upstream master: a loader, DMA or register-bus bridge. Each word is split into byte accesses on the `memaddr/memdatao/memrd/memwr/memack/memdatai` bus, and the sequencer waits for `memack` on every byte. Returned bytes are assembled into a 32-bit read word. An unacknowledged byte, such as an address outside the RAM window, ends the request with an error after a timeout, so the master never hangs.

## Interface
Parameters:
- `ADDR_W`, 23, byte-address width of the memory bus; the word address is `ADDR_W-2` bits.
- `TIMEOUT_CYCLES`, 16, maximum number of WAIT cycles per byte before abort; legal range is 2..255.

Ports:
- `clkin`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  `ADDR_W-2`  word address.
- `req_wdata`  in  32  write data, little-endian; byte k is `[8k+7:8k]`.
- `req_be`  in  4  write byte enables; ignored for reads, which always fetch all 4 bytes.
- `rsp_valid`  out  1  one-cycle completion pulse; the master cannot stall it.
- `rsp_rdata`  out  32  assembled read data, valid with `rsp_valid`.
- `rsp_err`  out  1  timeout occurred, valid with `rsp_valid`.
- `memaddr`  out  `ADDR_W`  byte address `{word_addr, k[1:0]}`.
- `memdatao`  out  8  write byte.
- `memrd`  out  1  read strobe.
- `memwr`  out  1  write strobe.
- `memack`  in  1  byte acknowledge, arriving one or more cycles after the strobe.
- `memdatai`  in  8  read byte, valid in the cycle `memack` is high.

## Operation
- **FSM states:**
  - IDLE: `req_ready` = 1.
  - ISSUE: the strobe for byte k is high for exactly 1 cycle.
  - WAIT: strobe low; the block waits for `memack`.
- **Accept:** on `req_valid && req_ready` the block latches addr, wdata and write. It also latches `mask = req_write ? req_be : 4'b1111` and clears the data and error registers.
  - If `mask == 0`, the request completes without any bus access: IDLE→IDLE with `rsp_valid` the next cycle.
  - Otherwise k = lowest set bit of mask and the FSM goes to ISSUE.
- **ISSUE:**
  - Drive `memaddr`, `memdatao` = wdata byte k, and `memrd`/`memwr` per the latched write flag.
  - Clear the timeout counter, then go to WAIT.
  - `memaddr`/`memdatao` hold their value through WAIT.
- **WAIT, `memack` = 1:**
  - On a read, store `memdatai` in `rsp_rdata` byte k.
  - Clear mask bit k.
  - If mask bits remain, set k = next set bit and go to ISSUE.
  - Otherwise go to IDLE and pulse `rsp_valid` with `rsp_err` = 0.
- **WAIT, no ack:** increment the counter. When it reaches `TIMEOUT_CYCLES-1`, go to IDLE and pulse `rsp_valid` with `rsp_err` = 1.
  - Bytes captured before the timeout are kept; the remaining bytes read as 0.
  - Remaining write bytes are not issued.
- `memack` in IDLE or ISSUE is ignored (treated as stray).
- `memack` in the same cycle as the timeout terminal count: the ack wins and there is no error.
- Bytes are issued in ascending k order only.

## Timing
- **Reset values:** `req_ready`=0 during reset and 1 after; all of the following are 0: `rsp_valid`, `rsp_err`, `rsp_rdata`, `memaddr`, `memdatao`, `memrd`, `memwr`; state = IDLE.
- All outputs are registered.
- **Per-byte cost:** 2 cycles when `memack` arrives in the first WAIT cycle; each extra ack delay cycle adds 1.
- **Full-word request accepted at cycle 0, zero-delay acks:**
  - Strobes high at cycles 1, 3, 5, 7.
  - Acks at cycles 2, 4, 6, 8.
  - `rsp_valid` and `req_ready` high at cycle 9.
- **Single-byte write:** strobe at cycle 1, `rsp_valid` at cycle 3.
- **`mask == 0`:** `rsp_valid` at cycle 1.
- **Back-to-back requests:** a request presented in the `rsp_valid` cycle is accepted in that cycle.
- **Timeout:** `rsp_valid` arrives `TIMEOUT_CYCLES` cycles after the last ISSUE cycle.
- **Reset mid-operation:** outputs drop asynchronously and no response is generated. A pending write may be partially performed; this is accepted behaviour.

## Structure
- **Shared package `mem_bridge_pkg`:**
  - FSM state encoding (IDLE/ISSUE/WAIT).
  - `BYTES_PER_WORD` = 4.
  - Default `TIMEOUT_CYCLES`.
- **One sub-module, `mem_be_scan`:** combinational lowest-set-bit finder over the 4-bit mask, producing a 2-bit index and an `any` flag. It is used both at accept and after each ack.
- Everything else lives in `mem_word_bridge`.

## Test plan
- **Full-word write then read:** write addr 0x0010, wdata 0xA1B2C3D4, be 4'hF. Expect `memaddr` 0x40..0x43 and `memdatao` D4, C3, B2, A1. The read then returns `rsp_rdata` 0xA1B2C3D4 at cycle 9 with `rsp_err` 0.
- **Sparse enables:** write be 4'b1010 with wdata 0x11223344. Expect exactly 2 strobes, at byte addresses +1 (data 0x33) and +3 (data 0x11), and `rsp_valid` at cycle 5. A read-back shows bytes 0 and 2 unchanged.
- **Zero enables:** write with be 0. Expect no `memwr` and `rsp_valid` at cycle 1.
- **Out-of-window timeout:** read at word addr 0x2000, byte 0x8000, which is never acked. Expect `rsp_valid` with `rsp_err` = 1 and `rsp_rdata` 0 after 1+`TIMEOUT_CYCLES` cycles, and only one `memrd` pulse.
- **Delayed and stray acks:** a bench-delayed ack of 3 cycles per byte gives `rsp_valid` at cycle 21. An ack on the exact timeout cycle gives `rsp_err` 0. A stray ack in IDLE produces no response.
- **Reset mid-word:** assert `rstn` low after byte 1 is issued. All strobes go low immediately and there is no `rsp_valid`. After release, a new read completes normally.
